// File: rtl/switch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : switch_pkg                                                   |
// | Description : Shared types and defaults for the ingress frame arbiter.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package switch_pkg;

  // Arbiter frame-level state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // Largest standard tagged Ethernet frame
  localparam int c_MAX_FRAME_BYTES_DFLT = 1522;
  // Mid-frame silence tolerated from the owning port
  localparam int c_STALL_TIMEOUT_DFLT   = 64;
  // Width of the optional statistics counters
  localparam int c_STAT_WIDTH           = 16;

endpackage : switch_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational N-way round-robin picker. Selects the first   |
// |               requester at or after i_rr_ptr, wrapping around.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_rr_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_any
);

  int w_cand;

  // Scan from the farthest offset back to offset 0 so the nearest requester wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_cand = (int'(i_rr_ptr) + k) % NUM_PORTS;
      if (i_req[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        o_idx           = IDX_W'(w_cand);
        o_any           = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ingress_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ingress_frame_arbiter                                        |
// | Description : Frame-granular round-robin arbiter sharing the frame-memory |
// |               write path between RX MAC ports. Muxes the owning port onto |
// |               a registered write bus and truncates over-long or stalled   |
// |               frames with an error beat.                                  |
// |               Optional: define INGRESS_ARB_STATS_EN for per-port frame    |
// |               and abort statistics counters.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ingress_frame_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_FRAME_BYTES = c_MAX_FRAME_BYTES_DFLT,
  parameter int STALL_TIMEOUT   = c_STALL_TIMEOUT_DFLT
) (
  input  logic                            switch_clk,
  input  logic                            switch_rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] frame_data_i,
  input  logic [NUM_PORTS-1:0]            frame_valid_i,
  input  logic [NUM_PORTS-1:0]            frame_sof_i,
  input  logic [NUM_PORTS-1:0]            frame_eof_i,
  input  logic [NUM_PORTS-1:0]            frame_error_i,
  output logic [NUM_PORTS-1:0]            frame_grant_o,
  input  logic                            wr_ready_i,
  output logic                            wr_valid_o,
  output logic [DATA_WIDTH-1:0]           wr_data_o,
  output logic                            wr_sof_o,
  output logic                            wr_eof_o,
  output logic                            wr_error_o,
  output logic [$clog2(NUM_PORTS)-1:0]    wr_port_o
`ifdef INGRESS_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*c_STAT_WIDTH-1:0] stat_frames_o,
  output logic [c_STAT_WIDTH-1:0]           stat_aborts_o
`endif
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int BCNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam int SCNT_W = $clog2(STALL_TIMEOUT + 1);

  localparam logic [BCNT_W-1:0] c_BCNT_MAX  = BCNT_W'(MAX_FRAME_BYTES);
  localparam logic [SCNT_W-1:0] c_SCNT_MAX  = SCNT_W'(STALL_TIMEOUT);
  localparam logic [PORT_W-1:0] c_LAST_PORT = PORT_W'(NUM_PORTS - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [PORT_W-1:0]     r_owner;
  logic [PORT_W-1:0]     r_rr_ptr;
  logic [NUM_PORTS-1:0]  r_grant;
  logic [BCNT_W-1:0]     r_byte_cnt;
  logic [SCNT_W-1:0]     r_stall_cnt;

  logic                  r_wr_valid;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_sof;
  logic                  r_wr_eof;
  logic                  r_wr_error;
  logic [PORT_W-1:0]     r_wr_port;

  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_win_onehot;
  logic [PORT_W-1:0]     w_win_idx;
  logic                  w_win_any;

  logic                  w_own_valid;
  logic                  w_own_eof;
  logic                  w_own_error;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic [BCNT_W-1:0]     w_byte_cnt_inc;
  logic [SCNT_W-1:0]     w_stall_cnt_inc;
  logic [PORT_W-1:0]     w_ptr_after_owner;

  logic                  w_start;
  logic                  w_emit_byte;
  logic                  w_emit_abort;
  logic                  w_done;

  // A port asks for the write path only with the first byte of a frame presented
  assign w_req = frame_valid_i & frame_sof_i;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (PORT_W)
  ) u_rr_arbiter (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  // Owner-port view of the input streams; other ports are ignored
  assign w_own_valid = frame_valid_i[r_owner];
  assign w_own_eof   = frame_eof_i[r_owner];
  assign w_own_error = frame_error_i[r_owner];
  assign w_own_data  = frame_data_i[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];

  // Saturating increments for the length and silence counters
  assign w_byte_cnt_inc  = (r_byte_cnt == c_BCNT_MAX) ? r_byte_cnt : r_byte_cnt + BCNT_W'(1);
  assign w_stall_cnt_inc = (r_stall_cnt == c_SCNT_MAX) ? r_stall_cnt : r_stall_cnt + SCNT_W'(1);
  assign w_ptr_after_owner = (r_owner == c_LAST_PORT) ? '0 : r_owner + PORT_W'(1);

  // Next-state and per-cycle actions; eof beats the length limit on the same byte
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_emit_byte  = 1'b0;
    w_emit_abort = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (wr_ready_i && w_win_any) begin
          w_start     = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_own_valid) begin
          w_emit_byte = 1'b1;
          if (w_own_eof) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_byte_cnt_inc == c_BCNT_MAX) begin
            w_state_nxt = ABORT;
          end
        end else if (w_stall_cnt_inc == c_SCNT_MAX) begin
          w_state_nxt = ABORT;
        end
      end
      ABORT: begin
        // An eof landing on the abort cycle closes the frame; no drain needed
        w_emit_abort = 1'b1;
        if (w_own_valid && w_own_eof) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_own_valid) begin
          if (w_own_eof) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (w_stall_cnt_inc == c_SCNT_MAX) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, ownership, grant and round-robin pointer registers
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_owner <= w_win_idx;
        r_grant <= w_win_onehot;
      end else if (w_done) begin
        r_grant  <= '0;
        r_rr_ptr <= w_ptr_after_owner;
      end
    end
  end

  // Frame length and owner-silence counters; silence restarts after the abort beat
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == XFER || r_state == DRAIN) begin
      if (w_own_valid) begin
        r_byte_cnt  <= w_byte_cnt_inc;
        r_stall_cnt <= '0;
      end else begin
        r_stall_cnt <= w_stall_cnt_inc;
      end
    end else if (r_state == ABORT) begin
      r_stall_cnt <= '0;
    end
  end

  // Registered write bus: accepted byte or synthetic error-terminating beat
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_wr_sof   <= 1'b0;
      r_wr_eof   <= 1'b0;
      r_wr_error <= 1'b0;
      r_wr_port  <= '0;
    end else if (w_emit_byte) begin
      r_wr_valid <= 1'b1;
      r_wr_data  <= w_own_data;
      r_wr_sof   <= (r_byte_cnt == '0);
      r_wr_eof   <= w_own_eof;
      r_wr_error <= w_own_eof & w_own_error;
      r_wr_port  <= r_owner;
    end else if (w_emit_abort) begin
      r_wr_valid <= 1'b1;
      r_wr_data  <= '0;
      r_wr_sof   <= 1'b0;
      r_wr_eof   <= 1'b1;
      r_wr_error <= 1'b1;
      r_wr_port  <= r_owner;
    end else begin
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_wr_sof   <= 1'b0;
      r_wr_eof   <= 1'b0;
      r_wr_error <= 1'b0;
      r_wr_port  <= '0;
    end
  end

  assign frame_grant_o = r_grant;
  assign wr_valid_o    = r_wr_valid;
  assign wr_data_o     = r_wr_data;
  assign wr_sof_o      = r_wr_sof;
  assign wr_eof_o      = r_wr_eof;
  assign wr_error_o    = r_wr_error;
  assign wr_port_o     = r_wr_port;

`ifdef INGRESS_ARB_STATS_EN
  logic [c_STAT_WIDTH-1:0] r_stat_aborts;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat_port
    logic [c_STAT_WIDTH-1:0] r_stat_frames;

    // Count every frame closed on this port, clean or truncated
    always_ff @(posedge switch_clk or posedge switch_rst) begin
      if (switch_rst) begin
        r_stat_frames <= '0;
      end else if (w_done && (r_owner == PORT_W'(p))) begin
        r_stat_frames <= r_stat_frames + c_STAT_WIDTH'(1);
      end
    end

    assign stat_frames_o[p*c_STAT_WIDTH +: c_STAT_WIDTH] = r_stat_frames;
  end

  // Count each entry into the abort state
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      r_stat_aborts <= '0;
    end else if (w_state_nxt == ABORT && r_state != ABORT) begin
      r_stat_aborts <= r_stat_aborts + c_STAT_WIDTH'(1);
    end
  end

  assign stat_aborts_o = r_stat_aborts;
`endif

endmodule : ingress_frame_arbiter
`default_nettype wire
